// File: rtl/geofence_driver.sv
// geofence_driver: host-side frame buffer and streamer for the geofence engine.
// Holds NPTS (X,Y,R) samples written by the host and streams them one per cycle
// onto X/Y/R. It then waits for the engine's valid/is_inside verdict, or for a
// timeout, and reports the result with a one-cycle res_valid strobe.
// Ports:
//   clk, reset            rising-edge clock, async active-low reset
//   wr_en/wr_idx/wr_x/y/r host buffer write (accepted only while idle)
//   start                 start-frame request (level, sampled while idle)
//   busy                  high while a frame is in flight
//   X, Y, R               registered sample bus to the engine
//   valid, is_inside      engine verdict
//   res_valid             one-cycle result strobe
//   res_inside            captured verdict
//   res_timeout           last frame timed out
//   frame_cnt, inside_cnt running 16-bit report counters
module geofence_driver #(
   parameter int unsigned NPTS    = 7,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  wr_idx,
   input  logic [9:0]  wr_x,
   input  logic [9:0]  wr_y,
   input  logic [10:0] wr_r,
   input  logic        start,
   output logic        busy,
   output logic [9:0]  X,
   output logic [9:0]  Y,
   output logic [10:0] R,
   input  logic        valid,
   input  logic        is_inside,
   output logic        res_valid,
   output logic        res_inside,
   output logic        res_timeout,
   output logic [15:0] frame_cnt,
   output logic [15:0] inside_cnt
);

   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned TMO_W = 8;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEND   = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [10:0] r;
   } sample_t;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   sample_t          r_buf [NPTS];
   sample_t          r_out;
   sample_t          w_wr_data;
   sample_t          w_first;
   logic             w_wr;
   logic [IDX_W-1:0] r_idx;
   logic [TMO_W-1:0] r_wait_cnt;
   logic             w_wait_last;
   logic             r_rep_ph;
   logic             r_busy;
   logic             r_res_valid;
   logic             r_res_inside;
   logic             r_res_timeout;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_inside_cnt;

   assign w_wr        = wr_en && (r_state == S_IDLE) && (wr_idx < IDX_W'(NPTS));
   assign w_wr_data   = {wr_x, wr_y, wr_r};
   assign w_wait_last = (r_wait_cnt == TMO_W'(TIMEOUT - 1));
   // A write to entry 0 on the start edge must be seen by the first sample.
   assign w_first     = (w_wr && (wr_idx == '0)) ? w_wr_data : r_buf[0];

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_SEND;
         S_SEND:   if (r_idx == IDX_W'(NPTS)) w_state_nxt = S_WAIT;
         S_WAIT:   if (valid || w_wait_last) w_state_nxt = S_REPORT;
         S_REPORT: if (r_rep_ph) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Buffer, sample stream, verdict capture and counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NPTS); i++) r_buf[i] <= '0;
         r_out         <= '0;
         r_idx         <= '0;
         r_wait_cnt    <= '0;
         r_rep_ph      <= 1'b0;
         r_busy        <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_inside  <= 1'b0;
         r_res_timeout <= 1'b0;
         r_frame_cnt   <= '0;
         r_inside_cnt  <= '0;
      end else begin
         r_busy      <= (w_state_nxt != S_IDLE);
         r_res_valid <= 1'b0;
         if (w_wr) r_buf[wr_idx] <= w_wr_data;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_out <= w_first;
                  r_idx <= IDX_W'(1);
               end
            end
            S_SEND: begin
               // r_idx is the next entry to present; NPTS means the frame is done.
               if (r_idx == IDX_W'(NPTS)) begin
                  r_out      <= '0;
                  r_wait_cnt <= '0;
               end else begin
                  r_out <= r_buf[r_idx];
                  r_idx <= IDX_W'(r_idx + IDX_W'(1));
               end
            end
            S_WAIT: begin
               if (valid) begin
                  r_res_inside  <= is_inside;
                  r_res_timeout <= 1'b0;
                  r_rep_ph      <= 1'b0;
               end else if (w_wait_last) begin
                  r_res_inside  <= 1'b0;
                  r_res_timeout <= 1'b1;
                  r_rep_ph      <= 1'b0;
               end else begin
                  r_wait_cnt <= TMO_W'(r_wait_cnt + TMO_W'(1));
               end
            end
            S_REPORT: begin
               // First REPORT cycle fires the strobe; second returns to idle.
               if (!r_rep_ph) begin
                  r_res_valid <= 1'b1;
                  r_frame_cnt <= CNT_W'(r_frame_cnt + CNT_W'(1));
                  if (r_res_inside) r_inside_cnt <= CNT_W'(r_inside_cnt + CNT_W'(1));
                  r_rep_ph    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = r_busy;
   assign X           = r_out.x;
   assign Y           = r_out.y;
   assign R           = r_out.r;
   assign res_valid   = r_res_valid;
   assign res_inside  = r_res_inside;
   assign res_timeout = r_res_timeout;
   assign frame_cnt   = r_frame_cnt;
   assign inside_cnt  = r_inside_cnt;

endmodule

// File: tb/tb_geofence_driver.sv
// Self-checking bench for geofence_driver. Inputs are driven and outputs are
// sampled on the falling edge. Expected values come from a buffer/counter
// model and the frame timing rules.
module tb_geofence_driver;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [2:0]  wr_idx;
   logic [9:0]  wr_x;
   logic [9:0]  wr_y;
   logic [10:0] wr_r;
   logic        start;
   logic        busy;
   logic [9:0]  X;
   logic [9:0]  Y;
   logic [10:0] R;
   logic        valid;
   logic        is_inside;
   logic        res_valid;
   logic        res_inside;
   logic        res_timeout;
   logic [15:0] frame_cnt;
   logic [15:0] inside_cnt;

   geofence_driver #(.NPTS(7), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx),
      .wr_x(wr_x), .wr_y(wr_y), .wr_r(wr_r), .start(start), .busy(busy),
      .X(X), .Y(Y), .R(R), .valid(valid), .is_inside(is_inside),
      .res_valid(res_valid), .res_inside(res_inside), .res_timeout(res_timeout),
      .frame_cnt(frame_cnt), .inside_cnt(inside_cnt)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [30:0] m_buf [7];
   logic [15:0] m_frames;
   logic [15:0] m_inside;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".xyr"}, 32'({X, Y, R}), 32'd0);
      check({tag, ".res"}, 32'({res_valid, res_inside, res_timeout}), 32'd0);
      check({tag, ".cnt"}, {frame_cnt, inside_cnt}, 32'd0);
   endtask

   task automatic host_write(input int idx, input logic [9:0] x, input logic [9:0] y,
                             input logic [10:0] r);
      wr_en = 1'b1; wr_idx = 3'(idx); wr_x = x; wr_y = y; wr_r = r;
      tick();
      wr_en = 1'b0;
      if (idx < 7) m_buf[idx] = {x, y, r};
   endtask

   // d = 0: no verdict (timeout); d >= 1: valid sampled d edges after WAIT entry.
   // junk drives writes/start/valid throughout SEND, all of which must be ignored.
   task automatic run_frame(input int d, input bit ins, input bit junk);
      bit exp_in;
      bit exp_to;
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         check($sformatf("send%0d.busy", k), 32'(busy), 32'd1);
         check($sformatf("send%0d.xyr", k), 32'({X, Y, R}), 32'(m_buf[k]));
         if (junk) begin
            wr_en = 1'b1; wr_idx = 3'd3; wr_x = 10'd999; wr_y = 10'd1; wr_r = 11'd1;
            start = 1'b1; valid = 1'b1; is_inside = 1'b1;
         end
         tick();
      end
      wr_en = 1'b0; start = 1'b0; valid = 1'b0; is_inside = 1'b0;
      check("post_send.xyr", 32'({X, Y, R}), 32'd0);
      check("post_send.busy", 32'(busy), 32'd1);
      if (d > 0) begin
         for (int i = 1; i < d; i++) begin
            check("wait.res_valid", 32'(res_valid), 32'd0);
            tick();
         end
         valid = 1'b1; is_inside = ins;
         tick();
         valid = 1'b0; is_inside = 1'b0;
         check("after_w.res_valid", 32'(res_valid), 32'd0);
         tick();
         exp_in = ins; exp_to = 1'b0;
      end else begin
         for (int i = 1; i <= int'(TO); i++) begin
            tick();
            check("timeout_wait.res_valid", 32'(res_valid), 32'd0);
         end
         tick();
         exp_in = 1'b0; exp_to = 1'b1;
      end
      m_frames = m_frames + 16'd1;
      if (exp_in) m_inside = m_inside + 16'd1;
      check("report.res_valid", 32'(res_valid), 32'd1);
      check("report.busy", 32'(busy), 32'd1);
      check("report.res_inside", 32'(res_inside), 32'(exp_in));
      check("report.res_timeout", 32'(res_timeout), 32'(exp_to));
      check("report.frame_cnt", 32'(frame_cnt), 32'(m_frames));
      check("report.inside_cnt", 32'(inside_cnt), 32'(m_inside));
      tick();
      check("end.res_valid", 32'(res_valid), 32'd0);
      check("end.busy", 32'(busy), 32'd0);
      check("end.res_inside_held", 32'(res_inside), 32'(exp_in));
      tick();
      check("no_requeue.busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_r = '0;
      start = 1'b0; valid = 1'b0; is_inside = 1'b0;
      for (int i = 0; i < 7; i++) m_buf[i] = '0;
      m_frames = '0; m_inside = '0;
      tick(); tick();
      check_all_zero("reset");
      reset = 1'b1;
      tick();
      check_all_zero("idle");

      // Directed ramp frame, then an inside verdict three cycles into WAIT.
      for (int k = 0; k < 7; k++)
         host_write(k, 10'(10 * k), 10'(20 * k), 11'(100 + k));
      host_write(7, 10'd555, 10'd555, 11'd555);
      run_frame(3, 1'b1, 1'b0);

      // Timeout frame.
      run_frame(0, 1'b1, 1'b0);

      // Verdicts while idle are ignored.
      valid = 1'b1; is_inside = 1'b1;
      tick(); tick();
      valid = 1'b0; is_inside = 1'b0;
      check("idle_valid.res_valid", 32'(res_valid), 32'd0);
      check("idle_valid.frame_cnt", 32'(frame_cnt), 32'(m_frames));

      // Writes, start and valid during SEND are ignored; buffer replays unchanged.
      run_frame(0, 1'b0, 1'b1);
      run_frame(2, 1'b0, 1'b0);

      // Randomized frames, including a write on the same edge as start.
      for (int n = 0; n < 8; n++) begin
         int nw;
         nw = int'($urandom_range(0, 4));
         for (int j = 0; j < nw; j++)
            host_write(int'($urandom_range(0, 7)), 10'($urandom), 10'($urandom), 11'($urandom));
         begin
            int si;
            si = int'($urandom_range(0, 6));
            wr_en = 1'b1; wr_idx = 3'(si);
            wr_x = 10'($urandom); wr_y = 10'($urandom); wr_r = 11'($urandom);
            m_buf[si] = {wr_x, wr_y, wr_r};
         end
         run_frame(int'($urandom_range(0, TO)), 1'($urandom), 1'b0);
      end

      // Reset asserted while sample 4 is on the bus.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rst_send%0d.xyr", k), 32'({X, Y, R}), 32'(m_buf[k]));
         if (k < 4) tick();
      end
      reset = 1'b0;
      #1;
      check_all_zero("midframe_reset");
      tick();
      reset = 1'b1;
      for (int i = 0; i < 7; i++) m_buf[i] = '0;
      m_frames = '0; m_inside = '0;
      tick();
      run_frame(1, 1'b0, 1'b0);

      // Counter wrap from 0xFFFF on an inside report.
      force dut.r_frame_cnt = 16'hFFFF;
      force dut.r_inside_cnt = 16'hFFFF;
      #1;
      release dut.r_frame_cnt;
      release dut.r_inside_cnt;
      m_frames = 16'hFFFF; m_inside = 16'hFFFF;
      tick();
      run_frame(1, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/geofence_driver.md
# geofence_driver

Transmit-side companion to the geofence engine: holds one frame of seven (X, Y, R) samples written by a host, streams them one per cycle onto the engine's X/Y/R input bus, then waits for the engine's valid/is_inside answer. It returns the verdict to the host with a one-cycle result strobe. It also keeps running frame and inside counters and a response timeout. It sits between the test/host controller and the geofence engine in the same clock domain.

## Interface
- NPTS, 7, samples per frame (entry 0 = object point, entries 1..6 = receivers)
- TIMEOUT, 255, max WAIT cycles before a frame is declared lost (1..255)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  host write strobe into frame buffer
- wr_idx  in  3  buffer entry index (0..6)
- wr_x  in  10  X sample
- wr_y  in  10  Y sample
- wr_r  in  11  R sample
- start  in  1  start-frame request (level sampled)
- busy  out  1  high in SEND/WAIT/REPORT
- X  out  10  sample X to engine (registered)
- Y  out  10  sample Y to engine (registered)
- R  out  11  sample R to engine (registered)
- valid  in  1  engine verdict strobe
- is_inside  in  1  engine verdict
- res_valid  out  1  one-cycle result strobe
- res_inside  out  1  captured verdict, held until next res_valid
- res_timeout  out  1  last frame timed out, held until next res_valid
- frame_cnt  out  16  frames reported (wraps)
- inside_cnt  out  16  frames reported inside (wraps)

## Operation
- States: IDLE, SEND, WAIT, REPORT. Reset → IDLE.
- IDLE: wr_en with wr_idx ≤ 6 writes entry. wr_idx 7 ignored. start=1 → SEND, index counter = 0.
- SEND: X/Y/R ← entry[idx] each cycle, idx 0..6. After idx 6 → WAIT, wait counter = 0. X/Y/R return to 0 on the cycle after the last sample.
- WAIT: valid=1 → capture is_inside, → REPORT, res_timeout cleared. Otherwise wait counter +1. When counter = TIMEOUT-1 with no valid → REPORT, res_inside=0, res_timeout=1.
- REPORT: res_valid=1 for exactly one cycle. frame_cnt+1. inside_cnt+1 if res_inside=1. → IDLE.
- wr_en and start are ignored while busy. The buffer is unchanged, so a frame can be resent by pulsing start again.
- valid seen in IDLE/SEND/REPORT is ignored: no capture, no counting.
- Counters are 16-bit modulo: 0xFFFF+1 → 0x0000.
- Reset mid-frame: immediate return to IDLE. All outputs go to 0 and buffer entries clear to 0.

## Timing
- Reset values: busy=0, X=Y=R=0, res_valid=0, res_inside=0, res_timeout=0, frame_cnt=0, inside_cnt=0.
- start sampled high at edge t: busy=1 and X/Y/R = entry0 after t. Entry k is presented after edge t+k, k=0..6. X/Y/R = 0 after t+7.
- valid sampled high at edge w in WAIT: res_valid=1 during cycle after w+1. busy=0 after w+2.
- Earliest accepted valid is at edge t+8. Minimum start-to-res_valid latency is 9 cycles.
- A new start is accepted no earlier than the edge after busy falls.
- Host write at edge e is visible to a start sampled at edge e or later: the write and start on the same edge use the new data.
- Timeout: with no valid, res_valid is asserted TIMEOUT+1 cycles after WAIT entry.

## Test plan
- Reset then idle: all outputs 0. Write entries 0..6 with X=10·k, Y=20·k, R=100+k, then start. X/Y/R show (0,0,100), (10,20,101) … (60,120,106) on consecutive cycles, then 0.
- valid=1, is_inside=1 three cycles after WAIT entry: one res_valid pulse, res_inside=1, res_timeout=0, frame_cnt=1, inside_cnt=1.
- No valid with TIMEOUT=4: res_valid pulse 5 cycles after WAIT entry, res_timeout=1, res_inside=0, frame_cnt+1, inside_cnt unchanged.
- While busy: wr_en to idx 3 with X=999, start=1, and valid=1 during SEND. Buffer is unchanged on the next frame, the start is not queued, and the SEND-phase valid is not captured.
- Assert reset at sample 4 of SEND: outputs 0 immediately. After release, a start with no writes streams seven all-zero samples.
- Preload frame_cnt/inside_cnt to 0xFFFF via 65535 inside frames (or force): the next inside report wraps both counters to 0x0000.
